// File: rtl/store_buffer.sv
// store_buffer: byte-masked store FIFO with newest-entry merging and load hazard detection
module store_buffer #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [WIDTH/8-1:0]      in_wea,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WIDTH/8-1:0]      mem_wea,
    output logic [WIDTH-1:0]        mem_data,
    input  logic                    ld_valid,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    output logic                    ld_hazard,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [WIDTH/8-1:0]    wea_q  [DEPTH];
    logic [WIDTH-1:0]      data_q [DEPTH];
    logic [PW-1:0]         head, tail, newest;
    logic                  pop, newest_popping, merge_ok, accept, do_push, do_merge, hit;
    logic [WIDTH-1:0]      merged;

    assign newest         = tail - PW'(1);
    assign empty          = (count == '0);
    assign mem_valid      = !empty;
    assign mem_addr       = addr_q[head];
    assign mem_data       = data_q[head];
    assign mem_wea        = mem_valid ? wea_q[head] : '0;
    assign pop            = mem_valid && mem_ready;
    assign newest_popping = pop && (count == CW'(1));
    assign merge_ok       = !empty && (addr_q[newest] == in_addr) && !newest_popping;
    assign in_ready       = (count < FULL) || merge_ok;
    assign accept         = in_valid && in_ready && (in_wea != '0);
    assign do_merge       = accept && merge_ok;
    assign do_push        = accept && !merge_ok;
    assign ld_hazard      = ld_valid && hit;

    // Overlay the incoming enabled lanes onto the newest entry's data
    always_comb begin
        merged = data_q[newest];
        for (int l = 0; l < WIDTH/8; l++)
            if (in_wea[l]) merged[8*l +: 8] = in_data[8*l +: 8];
    end

    // Any occupied slot (distance from head below count) holding the load address
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(PW'(i) - head)} < count && addr_q[i] == ld_addr) hit = 1'b1;
    end

    // FIFO state: pop at head, push at tail, or merge into the newest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                wea_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) head <= head + PW'(1);
            if (do_push) begin
                addr_q[tail] <= in_addr;
                wea_q[tail]  <= in_wea;
                data_q[tail] <= in_data;
                tail         <= tail + PW'(1);
            end
            if (do_merge) begin
                wea_q[newest]  <= wea_q[newest] | in_wea;
                data_q[newest] <= merged;
            end
            count <= count + CW'(do_push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table plus randomized run against a queue model
module tb_store_buffer;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, mem_valid, mem_ready, ld_valid, ld_hazard, empty;
    logic [13:0] in_addr, mem_addr, ld_addr;
    logic [3:0]  in_wea, mem_wea;
    logic [31:0] in_data, mem_data;
    logic [2:0]  count;

    store_buffer #(.WIDTH(32), .ADDR_WIDTH(14), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wea(in_wea), .in_data(in_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wea(mem_wea), .mem_data(mem_data), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_hazard(ld_hazard), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, iv; logic [13:0] ia; logic [3:0] iw; logic [31:0] id; logic mr, lv; logic [13:0] la;
        logic mv; logic [13:0] ma; logic [3:0] mw; logic [31:0] md; logic [2:0] cn; logic ir, hz, cad;
    } vec_t;
    typedef struct { logic [13:0] a; logic [3:0] w; logic [31:0] d; } ent_t;

    vec_t tv[$];
    ent_t mq[$];
    ent_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   thr;
    logic x_mv, x_ir, x_hz, x_pop, x_mok, x_acc;
    logic [13:0] x_ma;
    logic [3:0]  x_mw;
    logic [31:0] x_md;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    function automatic void v(logic r, iv, logic [13:0] ia, logic [3:0] iw, logic [31:0] id, logic mr, lv,
                              logic [13:0] la, logic mv, logic [13:0] ma, logic [3:0] mw, logic [31:0] md,
                              logic [2:0] cn, logic ir, hz, cad);
        tv.push_back('{r, iv, ia, iw, id, mr, lv, la, mv, ma, mw, md, cn, ir, hz, cad});
    endfunction

    task automatic check_all(string tag, logic mv, logic [13:0] ma, logic [3:0] mw, logic [31:0] md,
                             logic [2:0] cn, logic ir, logic hz, logic cad);
        chk({tag, " mem_valid"}, 32'(mem_valid), 32'(mv));
        chk({tag, " mem_wea"}, 32'(mem_wea), 32'(mw));
        chk({tag, " count"}, 32'(count), 32'(cn));
        chk({tag, " empty"}, 32'(empty), 32'(cn == 3'd0));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, " ld_hazard"}, 32'(ld_hazard), 32'(hz));
        if (mv || cad) begin
            chk({tag, " mem_addr"}, 32'(mem_addr), 32'(ma));
            chk({tag, " mem_data"}, mem_data, md);
        end
    endtask

    initial begin
        {rst, in_valid, in_addr, in_wea, in_data, mem_ready, ld_valid, ld_addr} = '0;
        rst = 1'b1;
        // rst iv  ia      iw    id            mr lv la       mv ma      mw    md            cn ir hz cad
        v(0, 1, 14'h010, 4'h1, 32'h000000AB, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 1);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 1, 14'h010, 4'h1, 32'h000000AB, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h010, 4'h1, 32'h000000AB, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h020, 4'h3, 32'h00001234, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h020, 4'hC, 32'h56780000, 0, 0, 14'h000, 1, 14'h020, 4'h3, 32'h00001234, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 1, 14'h020, 4'hF, 32'h56781234, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h020, 4'hF, 32'h56781234, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h100, 4'hF, 32'h11111111, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h101, 4'hF, 32'h22222222, 0, 0, 14'h000, 1, 14'h100, 4'hF, 32'h11111111, 1, 1, 0, 0);
        v(0, 1, 14'h102, 4'hF, 32'h33333333, 0, 0, 14'h000, 1, 14'h100, 4'hF, 32'h11111111, 2, 1, 0, 0);
        v(0, 1, 14'h103, 4'hF, 32'h44444444, 0, 0, 14'h000, 1, 14'h100, 4'hF, 32'h11111111, 3, 1, 0, 0);
        v(0, 1, 14'h104, 4'hF, 32'h55555555, 0, 0, 14'h000, 1, 14'h100, 4'hF, 32'h11111111, 4, 0, 0, 0);
        v(0, 1, 14'h103, 4'h1, 32'h000000AA, 0, 1, 14'h102, 1, 14'h100, 4'hF, 32'h11111111, 4, 1, 1, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h100, 4'hF, 32'h11111111, 4, 0, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h101, 4'hF, 32'h22222222, 3, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h102, 4'hF, 32'h33333333, 2, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h103, 4'hF, 32'h444444AA, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h030, 4'h3, 32'h0000AAAA, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h030, 4'hC, 32'hBBBB0000, 1, 0, 14'h000, 1, 14'h030, 4'h3, 32'h0000AAAA, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 1, 14'h030, 4'hC, 32'hBBBB0000, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h030, 4'hC, 32'hBBBB0000, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h040, 4'hF, 32'h00000001, 0, 1, 14'h040, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h041, 4'hF, 32'h00000002, 0, 1, 14'h041, 1, 14'h040, 4'hF, 32'h00000001, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 14'h041, 1, 14'h040, 4'hF, 32'h00000001, 2, 1, 1, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 14'h042, 1, 14'h040, 4'hF, 32'h00000001, 2, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 1, 14'h040, 1, 14'h040, 4'hF, 32'h00000001, 2, 1, 1, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h041, 1, 14'h041, 4'hF, 32'h00000002, 1, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h041, 4'hF, 32'h00000002, 1, 1, 0, 0);
        v(0, 1, 14'h050, 4'hF, 32'h00000005, 0, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 0);
        v(0, 1, 14'h051, 4'hF, 32'h00000006, 0, 0, 14'h000, 1, 14'h050, 4'hF, 32'h00000005, 1, 1, 0, 0);
        v(0, 1, 14'h052, 4'hF, 32'h00000007, 0, 0, 14'h000, 1, 14'h050, 4'hF, 32'h00000005, 2, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h050, 4'hF, 32'h00000005, 3, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 0, 0, 14'h000, 1, 14'h051, 4'hF, 32'h00000006, 2, 1, 0, 0);
        v(1, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 1, 14'h051, 4'hF, 32'h00000006, 2, 1, 0, 0);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 1, 14'h050, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 1);
        v(0, 1, 14'h060, 4'h0, 32'h000000FF, 1, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 1);
        v(0, 0, 14'h000, 4'h0, 32'h00000000, 1, 0, 14'h000, 0, 14'h000, 4'h0, 32'h00000000, 0, 1, 0, 1);
        repeat (2) @(negedge clk);
        foreach (tv[k]) begin
            {rst, in_valid, in_addr, in_wea, in_data} = {tv[k].r, tv[k].iv, tv[k].ia, tv[k].iw, tv[k].id};
            {mem_ready, ld_valid, ld_addr} = {tv[k].mr, tv[k].lv, tv[k].la};
            #1;
            check_all($sformatf("vec%0d", k), tv[k].mv, tv[k].ma, tv[k].mw, tv[k].md, tv[k].cn,
                      tv[k].ir, tv[k].hz, tv[k].cad);
            @(negedge clk);
        end
        thr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) thr = $urandom_range(10, 90);
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_addr   = 14'($urandom_range(0, 5));
            in_wea    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            in_data   = $urandom;
            mem_ready = ($urandom_range(0, 99) < thr);
            ld_valid  = $urandom_range(0, 1) == 1;
            ld_addr   = 14'($urandom_range(0, 5));
            #1;
            x_mv  = mq.size() != 0;
            x_ma  = x_mv ? mq[0].a : 14'h0;
            x_mw  = x_mv ? mq[0].w : 4'h0;
            x_md  = x_mv ? mq[0].d : 32'h0;
            x_pop = x_mv && mem_ready;
            x_mok = 1'b0;
            if (x_mv) x_mok = (mq[mq.size()-1].a == in_addr) && !(mq.size() == 1 && x_pop);
            x_ir  = (mq.size() < D) || x_mok;
            x_hz  = 1'b0;
            foreach (mq[k]) if (ld_valid && mq[k].a == ld_addr) x_hz = 1'b1;
            check_all($sformatf("rnd%0d", c), x_mv, x_ma, x_mw, x_md, 3'(mq.size()), x_ir, x_hz, 1'b0);
            if (rst) mq.delete();
            else begin
                x_acc = in_valid && x_ir && (in_wea != 4'h0);
                if (x_acc && x_mok) begin
                    e = mq[mq.size()-1];
                    for (int l = 0; l < 4; l++)
                        if (in_wea[l]) e.d[8*l +: 8] = in_data[8*l +: 8];
                    e.w = e.w | in_wea;
                    mq[mq.size()-1] = e;
                end
                if (x_pop) void'(mq.pop_front());
                if (x_acc && !x_mok) mq.push_back('{in_addr, in_wea, in_data});
            end
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
